video_scanlines: RTL and testbench

// - Post-scandoubler CRT scanline effect. Consumes the doubled-rate stream (ce_pix_out, hs/vs/hb/vb, rgb) from the

---
 rtl/video_pkg.sv | 36 +++
 rtl/sl_dim_channel.sv | 25 ++
 rtl/video_scanlines.sv | 128 ++++++++++++
 tb/tb_video_scanlines.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and constants for the scanline effect.
package video_pkg;

  localparam logic [1:0] SL_OFF = 2'd0;
  localparam logic [1:0] SL_25  = 2'd1;
  localparam logic [1:0] SL_50  = 2'd2;
  localparam logic [1:0] SL_75  = 2'd3;

  // Widest channel carried internally; narrower builds use the low bits.
  localparam int CMAX = 6;

  typedef struct packed {
    logic [CMAX-1:0] r;
    logic [CMAX-1:0] g;
    logic [CMAX-1:0] b;
  } rgb_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic hb;
    logic vb;
  } sync_t;

  typedef struct packed {
    rgb_t       rgb;
    sync_t      sy;
    logic       dim_en;
    logic [1:0] mode;
  } s1_t;

  function automatic int dwidth(input bit half_depth);
    return half_depth ? 3 : 5;
  endfunction

endpackage

// File: rtl/sl_dim_channel.sv
// Combinational per-channel scanline dim.
module sl_dim_channel
  import video_pkg::*;
#(
  parameter int W = 6
) (
  input  logic [W-1:0] c,
  input  logic [1:0]   mode,
  input  logic         en,
  output logic [W-1:0] y
);

  always_comb begin
    y = c;
    if (en) begin
      unique case (mode)
        SL_25:   y = c - (c >> 2);
        SL_50:   y = c >> 1;
        SL_75:   y = c >> 2;
        default: y = c;
      endcase
    end
  end

endmodule

// File: rtl/video_scanlines.sv
// CRT scanline effect: dims odd doubled lines, 2-stage ce_pix pipeline.
module video_scanlines
  import video_pkg::*;
#(
  parameter bit HALF_DEPTH = 1'b0
) (
  input  logic                         clk_vid,
  input  logic                         reset,
  input  logic                         ce_pix,
  input  logic [1:0]                   mode,
  input  logic                         hs_in,
  input  logic                         vs_in,
  input  logic                         hb_in,
  input  logic                         vb_in,
  input  logic [dwidth(HALF_DEPTH):0]  r_in,
  input  logic [dwidth(HALF_DEPTH):0]  g_in,
  input  logic [dwidth(HALF_DEPTH):0]  b_in,
  output logic                         ce_pix_out,
  output logic                         hs_out,
  output logic                         vs_out,
  output logic                         hb_out,
  output logic                         vb_out,
  output logic [dwidth(HALF_DEPTH):0]  r_out,
  output logic [dwidth(HALF_DEPTH):0]  g_out,
  output logic [dwidth(HALF_DEPTH):0]  b_out
);

  localparam int DWIDTH = dwidth(HALF_DEPTH);
  localparam int W = DWIDTH + 1;

  s1_t        s1_q, s1_d;
  rgb_t       s2_rgb_q, s2_rgb_d;
  sync_t      s2_sy_q, s2_sy_d;
  logic       parity_q, parity_d;
  logic [1:0] mode_l_q, mode_l_d;
  logic       hs_prev_q, hs_prev_d;
  logic       vs_prev_q, vs_prev_d;
  logic       ce_out_q;

  logic       hs_rise, vs_rise, s1_blank;
  logic [W-1:0] r_dim, g_dim, b_dim;

  assign hs_rise  = hs_in & ~hs_prev_q;
  assign vs_rise  = vs_in & ~vs_prev_q;
  assign s1_blank = s1_q.sy.hb | s1_q.sy.vb;

  sl_dim_channel #(.W(W)) u_dim_r (
    .c(s1_q.rgb.r[W-1:0]), .mode(s1_q.mode),
    .en(s1_q.dim_en), .y(r_dim)
  );
  sl_dim_channel #(.W(W)) u_dim_g (
    .c(s1_q.rgb.g[W-1:0]), .mode(s1_q.mode),
    .en(s1_q.dim_en), .y(g_dim)
  );
  sl_dim_channel #(.W(W)) u_dim_b (
    .c(s1_q.rgb.b[W-1:0]), .mode(s1_q.mode),
    .en(s1_q.dim_en), .y(b_dim)
  );

  always_comb begin
    s1_d      = s1_q;
    s2_rgb_d  = s2_rgb_q;
    s2_sy_d   = s2_sy_q;
    parity_d  = parity_q;
    mode_l_d  = mode_l_q;
    hs_prev_d = hs_prev_q;
    vs_prev_d = vs_prev_q;
    if (ce_pix) begin
      hs_prev_d = hs_in;
      vs_prev_d = vs_in;
      // vs clear wins so the first line of a frame is even
      if (vs_rise) begin
        parity_d = 1'b0;
        mode_l_d = mode;
      end else if (hs_rise) begin
        parity_d = ~parity_q;
      end

      s1_d.rgb.r  = CMAX'(r_in);
      s1_d.rgb.g  = CMAX'(g_in);
      s1_d.rgb.b  = CMAX'(b_in);
      s1_d.sy     = '{hs: hs_in, vs: vs_in, hb: hb_in, vb: vb_in};
      s1_d.mode   = mode_l_q;
      s1_d.dim_en = parity_q & (|mode_l_q) & ~(hb_in | vb_in);

      s2_sy_d = s1_q.sy;
      if (s1_blank) begin
        s2_rgb_d = '0;
      end else begin
        s2_rgb_d.r = CMAX'(r_dim);
        s2_rgb_d.g = CMAX'(g_dim);
        s2_rgb_d.b = CMAX'(b_dim);
      end
    end
  end

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      s1_q      <= '0;
      s2_rgb_q  <= '0;
      s2_sy_q   <= '0;
      parity_q  <= 1'b0;
      mode_l_q  <= SL_OFF;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      ce_out_q  <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_rgb_q  <= s2_rgb_d;
      s2_sy_q   <= s2_sy_d;
      parity_q  <= parity_d;
      mode_l_q  <= mode_l_d;
      hs_prev_q <= hs_prev_d;
      vs_prev_q <= vs_prev_d;
      ce_out_q  <= ce_pix;
    end
  end

  assign ce_pix_out = ce_out_q;
  assign hs_out     = s2_sy_q.hs;
  assign vs_out     = s2_sy_q.vs;
  assign hb_out     = s2_sy_q.hb;
  assign vb_out     = s2_sy_q.vb;
  assign r_out      = s2_rgb_q.r[W-1:0];
  assign g_out      = s2_rgb_q.g[W-1:0];
  assign b_out      = s2_rgb_q.b[W-1:0];

endmodule

// File: tb/tb_video_scanlines.sv
// Scoreboard bench for video_scanlines, full and half colour depth.
module tb_video_scanlines;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, ce;
  logic [1:0] mode;
  logic       hs_in, vs_in, hb_in, vb_in;
  logic [5:0] r_in, g_in, b_in;

  logic       ce0, hs0, vs0, hb0, vb0;
  logic [5:0] r0, g0, b0;
  logic       ce1, hs1, vs1, hb1, vb1;
  logic [3:0] r1, g1, b1;

  video_scanlines #(.HALF_DEPTH(1'b0)) dut0 (
    .clk_vid(clk), .reset(reset), .ce_pix(ce), .mode(mode),
    .hs_in(hs_in), .vs_in(vs_in), .hb_in(hb_in), .vb_in(vb_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .ce_pix_out(ce0), .hs_out(hs0), .vs_out(vs0),
    .hb_out(hb0), .vb_out(vb0),
    .r_out(r0), .g_out(g0), .b_out(b0)
  );

  video_scanlines #(.HALF_DEPTH(1'b1)) dut1 (
    .clk_vid(clk), .reset(reset), .ce_pix(ce), .mode(mode),
    .hs_in(hs_in), .vs_in(vs_in), .hb_in(hb_in), .vb_in(vb_in),
    .r_in(r_in[3:0]), .g_in(g_in[3:0]), .b_in(b_in[3:0]),
    .ce_pix_out(ce1), .hs_out(hs1), .vs_out(vs1),
    .hb_out(hb1), .vb_out(vb1),
    .r_out(r1), .g_out(g1), .b_out(b1)
  );

  typedef struct packed {
    logic [5:0] r, g, b;
    logic       hs, vs, hb, vb;
    logic [3:0] r1, g1, b1;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;
  logic [38:0] last, mon_a, mon_ev;
  exp_t mon_e;

  localparam logic [5:0] F6 = 6'h3F;
  localparam logic [3:0] F4 = 4'hF;

  function automatic logic [38:0] act_vec();
    return {r0, g0, b0, hs0, vs0, hb0, vb0,
            r1, g1, b1, hs1, vs1, hb1, vb1, ce1};
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      mon_a = act_vec();
      if (ce0) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL underflow: output %h with empty queue", mon_a);
        end else begin
          mon_e  = q.pop_front();
          mon_ev = {mon_e.r, mon_e.g, mon_e.b,
                    mon_e.hs, mon_e.vs, mon_e.hb, mon_e.vb,
                    mon_e.r1, mon_e.g1, mon_e.b1,
                    mon_e.hs, mon_e.vs, mon_e.hb, mon_e.vb, 1'b1};
          if (mon_a !== mon_ev) begin
            errors++;
            $display("FAIL pixel t=%0t: got %h exp %h", $time, mon_a, mon_ev);
          end
        end
        last = mon_a;
      end else begin
        checks++;
        if (mon_a !== {last[38:1], 1'b0}) begin
          errors++;
          $display("FAIL hold t=%0t: got %h exp %h", $time, mon_a,
                   {last[38:1], 1'b0});
        end
      end
    end
  end

  task automatic pix(input logic h, v, hbl, vbl,
                     input logic [5:0] r, g, b, er, eg, eb,
                     input logic [3:0] e1r, e1g, e1b);
    exp_t e;
    @(posedge clk); #1;
    ce = 1'b1; hs_in = h; vs_in = v; hb_in = hbl; vb_in = vbl;
    r_in = r; g_in = g; b_in = b;
    e = '{r: er, g: eg, b: eb, hs: h, vs: v, hb: hbl, vb: vbl,
          r1: e1r, g1: e1g, b1: e1b};
    q.push_back(e);
    @(posedge clk); #1;
    ce = 1'b0;
  endtask

  task automatic px(input logic [5:0] r, g, b, er, eg, eb,
                    input logic [3:0] e1r, e1g, e1b);
    pix(1'b0, 1'b0, 1'b0, 1'b0, r, g, b, er, eg, eb, e1r, e1g, e1b);
  endtask

  task automatic hsync_line();
    pix(1'b1, 1'b0, 1'b1, 1'b0, F6, F6, F6, 0, 0, 0, 0, 0, 0);
    pix(1'b0, 1'b0, 1'b1, 1'b0, F6, F6, F6, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic vsync();
    pix(1'b1, 1'b1, 1'b1, 1'b1, F6, F6, F6, 0, 0, 0, 0, 0, 0);
    pix(1'b0, 1'b0, 1'b1, 1'b1, F6, F6, F6, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; mode = 2'd0;
    hs_in = 1'b0; vs_in = 1'b0; hb_in = 1'b0; vb_in = 1'b0;
    r_in = F6; g_in = F6; b_in = F6;
    repeat (3) begin
      @(posedge clk); #1 ce = 1'b1;
      @(posedge clk); #1 ce = 1'b0;
      @(negedge clk);
      checks++;
      if ({act_vec(), ce0} !== '0) begin
        errors++;
        $display("FAIL reset: got %h exp 0", {act_vec(), ce0});
      end
    end
    @(posedge clk); #1 reset = 1'b0;
    last = '0;
    q.push_back('0);
    armed = 1'b1;

    // latency, sync alignment, odd line with mode 0
    px(F6, F6, F6, F6, F6, F6, F4, F4, F4);
    hsync_line();
    px(F6, F6, F6, F6, F6, F6, F4, F4, F4);

    // 25%: vs+hs together -> even line, then odd line dimmed
    mode = 2'd1;
    vsync();
    px(F6, F6, F6, F6, F6, F6, F4, F4, F4);
    hsync_line();
    px(F6, F6, F6, 6'h30, 6'h30, 6'h30, 4'hC, 4'hC, 4'hC);
    px(F6, 6'h20, 6'h10, 6'h30, 6'h18, 6'h0C, 4'hC, 4'h0, 4'h0);
    hsync_line();
    px(F6, F6, F6, F6, F6, F6, F4, F4, F4);

    // 50%, then mid-frame request for 75% must wait for vs
    mode = 2'd2;
    vsync();
    px(F6, F6, F6, F6, F6, F6, F4, F4, F4);
    hsync_line();
    px(F6, 6'h2A, F6, 6'h1F, 6'h15, 6'h1F, 4'h7, 4'h5, 4'h7);
    mode = 2'd3;
    hsync_line();
    px(F6, F6, F6, F6, F6, F6, F4, F4, F4);
    hsync_line();
    px(F6, F6, F6, 6'h1F, 6'h1F, 6'h1F, 4'h7, 4'h7, 4'h7);
    vsync();
    px(F6, F6, F6, F6, F6, F6, F4, F4, F4);
    hsync_line();
    px(F6, F6, 6'h2A, 6'h0F, 6'h0F, 6'h0A, 4'h3, 4'h3, 4'h2);

    // blanking forces black
    pix(1'b0, 1'b0, 1'b1, 1'b0, 6'h2A, 6'h2A, 6'h2A, 0, 0, 0, 0, 0, 0);
    pix(1'b0, 1'b0, 1'b0, 1'b1, 6'h2A, 6'h2A, 6'h2A, 0, 0, 0, 0, 0, 0);
    px(F6, F6, F6, 6'h0F, 6'h0F, 6'h0F, 4'h3, 4'h3, 4'h3);

    // ce gap: monitor checks outputs are frozen
    repeat (5) @(posedge clk);
    px(F6, F6, F6, 6'h0F, 6'h0F, 6'h0F, 4'h3, 4'h3, 4'h3);

    // mode 0: odd line undimmed
    mode = 2'd0;
    vsync();
    hsync_line();
    px(F6, F6, F6, F6, F6, F6, F4, F4, F4);

    px(0, 0, 0, 0, 0, 0, 0, 0, 0);
    px(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 1) begin
      errors++;
      $display("FAIL drain: queue size %0d exp 1", q.size());
    end
    armed = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
